// File: rtl/clock_pkg.sv
// Shared constants for the digital-clock blocks: mode encodings, default rates,
// key indices and a counter-width helper.
package clock_pkg;

  localparam logic [1:0] MODE_RUN     = 2'b00;
  localparam logic [1:0] MODE_SET_HR  = 2'b01;
  localparam logic [1:0] MODE_SET_MIN = 2'b10;

  localparam int DEF_CLK_HZ        = 1000;
  localparam int DEF_DEB_CYCLES    = 20;
  localparam int DEF_HOLD_CYCLES   = 500;
  localparam int DEF_REPEAT_CYCLES = 200;

  localparam int KEY_MODE = 0;
  localparam int KEY_INC  = 1;
  localparam int NUM_KEYS = 2;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, stable-count debouncer and one-cycle press pulse for
// one raw push-button.
module key_debounce
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic level,
  output logic press
);

  localparam int CW = cnt_width(DEB_CYCLES);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          level_d_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      press_reg   <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      sync1_reg   <= key;
      sync2_reg   <= sync1_reg;
      level_d_reg <= level_reg;
      press_reg   <= level_reg & ~level_d_reg;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/clock_mode_ctrl.sv
// RUN / SET_HR / SET_MIN sequencer with one-second prescaler and blink strobe.
// Optional held-key auto-repeat is enabled by defining DCLK_AUTOREPEAT_EN.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ        = DEF_CLK_HZ,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_key,
  input  logic       inc_key,
  output logic       tick_en,
  output logic       min_inc,
  output logic       hr_inc,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int PW        = cnt_width(CLK_HZ);
  localparam int BLINK_DIV = (CLK_HZ / 4 < 1) ? 1 : CLK_HZ / 4;
  localparam int BW        = cnt_width(BLINK_DIV);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;

  assign key_raw[KEY_MODE] = mode_key;
  assign key_raw[KEY_INC]  = inc_key;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_key (
      .clk  (clk),
      .reset(reset),
      .key  (key_raw[gi]),
      .level(key_level[gi]),
      .press(key_press[gi])
    );
  end

  logic mode_press;
  logic inc_press;
  logic inc_level;
  logic unused_levels;

  assign mode_press    = key_press[KEY_MODE];
  assign inc_press     = key_press[KEY_INC];
  assign inc_level     = key_level[KEY_INC];
  assign unused_levels = ^key_level;

  logic [1:0]    mode_reg, mode_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          tick_en_reg, tick_en_next;
  logic          min_inc_reg, min_inc_next;
  logic          hr_inc_reg, hr_inc_next;
  logic          sec_clr_reg, sec_clr_next;
  logic          blink_reg, blink_next;
  logic          rep_fire;
  logic          inc_event;
  logic          mode_change;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg      <= MODE_RUN;
      presc_reg     <= '0;
      blink_cnt_reg <= '0;
      tick_en_reg   <= 1'b0;
      min_inc_reg   <= 1'b0;
      hr_inc_reg    <= 1'b0;
      sec_clr_reg   <= 1'b0;
      blink_reg     <= 1'b0;
    end else begin
      mode_reg      <= mode_next;
      presc_reg     <= presc_next;
      blink_cnt_reg <= blink_cnt_next;
      tick_en_reg   <= tick_en_next;
      min_inc_reg   <= min_inc_next;
      hr_inc_reg    <= hr_inc_next;
      sec_clr_reg   <= sec_clr_next;
      blink_reg     <= blink_next;
    end
  end

  always_comb begin
    mode_next = mode_reg;
    case (mode_reg)
      MODE_RUN:     if (mode_press) mode_next = MODE_SET_HR;
      MODE_SET_HR:  if (mode_press) mode_next = MODE_SET_MIN;
      MODE_SET_MIN: if (mode_press) mode_next = MODE_RUN;
      default:      mode_next = MODE_RUN;
    endcase
  end

  // Outputs are computed from the next state so they land in the same cycle
  // as the mode update.
  always_comb begin
    mode_change    = (mode_next != mode_reg);
    presc_next     = '0;
    tick_en_next   = 1'b0;
    blink_cnt_next = '0;
    blink_next     = 1'b0;
    inc_event      = (inc_press | rep_fire) & ~mode_press;
    hr_inc_next    = inc_event && (mode_reg == MODE_SET_HR);
    min_inc_next   = inc_event && (mode_reg == MODE_SET_MIN);
    sec_clr_next   = (mode_reg == MODE_SET_MIN) && (mode_next == MODE_RUN);

    if ((mode_reg == MODE_RUN) && (mode_next == MODE_RUN)) begin
      if (presc_reg != PW'(CLK_HZ - 1)) begin
        presc_next = presc_reg + PW'(1);
      end
    end
    tick_en_next = (mode_next == MODE_RUN) && (presc_next == PW'(CLK_HZ - 1));

    if ((mode_next != MODE_RUN) && !mode_change) begin
      if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
        blink_next = ~blink_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + BW'(1);
        blink_next     = blink_reg;
      end
    end
  end

`ifdef DCLK_AUTOREPEAT_EN
  localparam int REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW      = cnt_width(REP_MAX);

  logic          rep_active_reg;
  logic          rep_first_reg;
  logic [RW-1:0] rep_cnt_reg;
  logic [RW-1:0] rep_target;
  logic          set_mode;

  assign set_mode   = (mode_reg == MODE_SET_HR) || (mode_reg == MODE_SET_MIN);
  assign rep_target = rep_first_reg ? RW'(HOLD_CYCLES - 1) : RW'(REPEAT_CYCLES - 1);
  assign rep_fire   = rep_active_reg && inc_level && set_mode && !mode_press &&
                      (rep_cnt_reg == rep_target);

  // The repeat timer starts the cycle after the press pulse and dies on
  // release or any mode change.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_active_reg <= 1'b0;
      rep_first_reg  <= 1'b0;
      rep_cnt_reg    <= '0;
    end else if (mode_press || !inc_level || !set_mode) begin
      rep_active_reg <= 1'b0;
      rep_cnt_reg    <= '0;
    end else if (inc_press) begin
      rep_active_reg <= 1'b1;
      rep_first_reg  <= 1'b1;
      rep_cnt_reg    <= '0;
    end else if (rep_active_reg) begin
      if (rep_fire) begin
        rep_first_reg <= 1'b0;
        rep_cnt_reg   <= '0;
      end else begin
        rep_cnt_reg <= rep_cnt_reg + RW'(1);
      end
    end
  end
`else
  localparam int unused_rep_cycles = HOLD_CYCLES + REPEAT_CYCLES;
  assign rep_fire = 1'b0;
`endif

  assign mode    = mode_reg;
  assign tick_en = tick_en_reg;
  assign min_inc = min_inc_reg;
  assign hr_inc  = hr_inc_reg;
  assign sec_clr = sec_clr_reg;
  assign blink   = blink_reg;

endmodule
